// File: rtl/velocity_cell_access_ctrl_if.sv
// velocity_cell_access_ctrl_if: write-back request and velocity RAM port bundle
interface velocity_cell_access_ctrl_if #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 8
);
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_grant;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_rden;
  logic                  mem_wren;
  logic [DATA_WIDTH-1:0] mem_q;
  modport master (
    input  wr_req, wr_addr, wr_data, mem_q,
    output wr_grant, mem_address, mem_data, mem_rden, mem_wren
  );
  modport slave (
    output wr_req, wr_addr, wr_data, mem_q,
    input  wr_grant, mem_address, mem_data, mem_rden, mem_wren
  );
endinterface

// File: rtl/velocity_cell_access_ctrl.sv
// velocity_cell_access_ctrl: count-read + velocity stream sequencer sharing one RAM port with write-back
module velocity_cell_access_ctrl #(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rd_start,
  velocity_cell_access_ctrl_if.master bus,
  output logic                        out_valid,
  output logic [ADDR_WIDTH-1:0]       out_particle_id,
  output logic [DATA_WIDTH-1:0]       out_velocity,
  output logic [ADDR_WIDTH-1:0]       particle_count,
  output logic                        busy,
  output logic                        done,
  output logic                        cnt_err
);
  localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);
  typedef enum logic [2:0] {IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN, DONE} state_t;
  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] raw_cnt;
  logic                  over;
  logic                  want_rd;
  logic                  issue;
  logic [ADDR_WIDTH-1:0] rd_addr;
  // Write-back owns the port whenever it asks; a wanted read simply waits
  always_comb begin
    want_rd             = state == RD_CNT || state == STREAM;
    issue               = want_rd && !bus.wr_req;
    rd_addr             = state == STREAM ? ptr : '0;
    raw_cnt             = bus.mem_q[ADDR_WIDTH-1:0];
    over                = raw_cnt > MAX_CNT;
    bus.wr_grant        = bus.wr_req;
    bus.mem_wren        = bus.wr_req;
    bus.mem_rden        = issue;
    bus.mem_address     = bus.wr_req ? bus.wr_addr : rd_addr;
    bus.mem_data        = bus.wr_data;
    out_velocity        = out_valid ? bus.mem_q : '0;
  end
  // Pass sequencing; out_valid doubles as the pending-read flag so the RAM word lines up with its id
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      ptr             <= '0;
      particle_count  <= '0;
      out_valid       <= 1'b0;
      out_particle_id <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      cnt_err         <= 1'b0;
    end else begin
      out_valid <= issue && state == STREAM;
      done      <= 1'b0;
      if (issue && state == STREAM) out_particle_id <= ptr;
      case (state)
        IDLE: if (rd_start) begin
          state <= RD_CNT;
          busy  <= 1'b1;
        end
        RD_CNT: if (issue) state <= WAIT_CNT;
        WAIT_CNT: begin
          particle_count <= over ? MAX_CNT : raw_cnt;
          cnt_err        <= cnt_err | over;
          ptr            <= ADDR_WIDTH'(1);
          state          <= raw_cnt == '0 ? DONE : STREAM;
          done           <= raw_cnt == '0;
        end
        STREAM: if (issue) begin
          ptr <= ptr + 1'b1;
          if (ptr == particle_count) state <= DRAIN;
        end
        DRAIN: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_velocity_cell_access_ctrl.sv
// tb_velocity_cell_access_ctrl: scoreboard bench with behavioural single-port RAM
module tb_velocity_cell_access_ctrl;
  localparam int DW = 96;
  localparam int AW = 8;
  typedef struct {
    logic [AW-1:0] id;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;
  logic          clk = 1'b0;
  logic          rst;
  logic          rd_start;
  logic          out_valid;
  logic [AW-1:0] out_particle_id;
  logic [DW-1:0] out_velocity;
  logic [AW-1:0] particle_count;
  logic          busy;
  logic          done;
  logic          cnt_err;
  logic [DW-1:0] ram [256];
  logic [DW-1:0] q;
  int            cyc = 0;
  int            base = 0;
  int            n_chk = 0;
  int            n_pass = 0;
  exp_t          sb[$];
  velocity_cell_access_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  velocity_cell_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(220)) dut (
    .clk(clk),
    .rst(rst),
    .rd_start(rd_start),
    .bus(bus),
    .out_valid(out_valid),
    .out_particle_id(out_particle_id),
    .out_velocity(out_velocity),
    .particle_count(particle_count),
    .busy(busy),
    .done(done),
    .cnt_err(cnt_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // single-port RAM with one-cycle read latency
  always @(posedge clk) begin
    if (bus.mem_wren) ram[bus.mem_address] <= bus.mem_data;
    if (bus.mem_rden) q <= ram[bus.mem_address];
  end
  assign bus.mem_q = q;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc - base);
  endtask
  function automatic logic [DW-1:0] vw(input int s, input int k);
    return {32'(s), 32'(k), 32'(k * s + 7)};
  endfunction
  task automatic load(input logic [DW-1:0] cnt_word, input int s, input int n);
    ram[0] = cnt_word;
    for (int k = 1; k <= n; k++) ram[k] = vw(s, k);
  endtask
  task automatic push(input int id, input logic [DW-1:0] data, input int c);
    exp_t e;
    e.id = AW'(id);
    e.data = data;
    e.cyc = c;
    sb.push_back(e);
  endtask
  // every streamed word must match the oldest expected entry, including its cycle
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) check("unexp_valid", 128'(out_valid), 128'(0));
      else begin
        exp_t e;
        e = sb.pop_front();
        check("out_id", 128'(out_particle_id), 128'(e.id));
        check("out_vel", 128'(out_velocity), 128'(e.data));
        check("out_cyc", 128'(cyc - base), 128'(e.cyc));
      end
    end
  end
  task automatic run_pass(input int done_exp, input int lim, input int rst_cyc, input int wf, input int wt,
                          input logic [AW-1:0] wa, input logic [DW-1:0] wd, input int s1, input int s2,
                          input bit chk_rd0);
    int busy_end;
    busy_end = done_exp >= 0 ? done_exp : rst_cyc;
    for (int c = 0; c <= lim; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) base = cyc;
      rd_start = c == 0 || c == s1 || c == s2;
      rst = c == rst_cyc;
      bus.wr_req = c >= wf && c <= wt;
      bus.wr_addr = wa;
      bus.wr_data = wd;
      @(negedge clk);
      check("busy", 128'(busy), 128'(c >= 1 && c <= busy_end));
      check("done", 128'(done), 128'(c == done_exp));
      if (bus.wr_req) begin
        check("wr_grant", 128'({bus.wr_grant, bus.mem_wren, bus.mem_rden}), 128'(3'b110));
        check("wr_addr", 128'(bus.mem_address), 128'(wa));
        check("wr_data", 128'(bus.mem_data), 128'(wd));
      end
      if (chk_rd0 && c == 1) check("rd0", 128'({bus.mem_rden, bus.mem_address}), 128'({1'b1, 8'd0}));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd_start = 1'b0;
    bus.wr_req = 1'b0;
    check("sb_empty", 128'(sb.size()), 128'(0));
  endtask
  initial begin
    rst = 1'b1;
    rd_start = 1'b0;
    bus.wr_req = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    q = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_flags", 128'({out_valid, done, busy, cnt_err}), 128'(0));
    check("rst_regs", 128'({particle_count, out_particle_id}), 128'(0));
    check("rst_vel", 128'(out_velocity), 128'(0));
    // basic three-word pass
    load(96'd3, 1, 3);
    for (int k = 1; k <= 3; k++) push(k, vw(1, k), 3 + k);
    run_pass(7, 8, -1, -1, -2, '0, '0, -1, -1, 1'b1);
    check("pc_3", 128'(particle_count), 128'(3));
    // empty cell, with a write-back accepted alongside rd_start in IDLE
    load(96'd0, 2, 0);
    run_pass(3, 4, -1, 0, 0, 8'd100, vw(9, 9), -1, -1, 1'b0);
    check("pc_0", 128'(particle_count), 128'(0));
    check("cnt_err_0", 128'(cnt_err), 128'(0));
    check("wr_idle", 128'(ram[100]), 128'(vw(9, 9)));
    // oversized count is clamped and flagged
    load(96'd250, 3, 219);
    for (int k = 1; k <= 219; k++) push(k, vw(3, k), 3 + k);
    run_pass(223, 224, -1, -1, -2, '0, '0, -1, -1, 1'b1);
    check("cnt_err_1", 128'(cnt_err), 128'(1));
    check("pc_clamp", 128'(particle_count), 128'(219));
    // write-back collides with the issue of address 2
    load(96'd3, 4, 3);
    push(1, vw(4, 1), 4);
    push(2, vw(7, 7), 6);
    push(3, vw(4, 3), 7);
    run_pass(8, 9, -1, 4, 4, 8'd2, vw(7, 7), -1, -1, 1'b1);
    check("wr_collide", 128'(ram[2]), 128'(vw(7, 7)));
    // long write burst stalls the count read; mid-pass rd_start ignored
    load(96'd2, 5, 2);
    push(1, vw(5, 1), 9);
    push(2, vw(5, 2), 10);
    run_pass(11, 14, -1, 1, 5, 8'd50, vw(8, 8), 3, 8, 1'b0);
    check("wr_burst", 128'(ram[50]), 128'(vw(8, 8)));
    check("pc_2", 128'(particle_count), 128'(2));
    // reset while id 2 is being delivered aborts the pass silently
    load(96'd3, 6, 3);
    push(1, vw(6, 1), 4);
    push(2, vw(6, 2), 5);
    run_pass(-1, 10, 5, -1, -2, '0, '0, -1, -1, 1'b1);
    check("pc_rst", 128'(particle_count), 128'(0));
    for (int k = 1; k <= 3; k++) push(k, vw(6, k), 3 + k);
    run_pass(7, 8, -1, -1, -2, '0, '0, -1, -1, 1'b1);
    check("pc_restart", 128'(particle_count), 128'(3));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
